// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, most significant first,
// accumulating acc*10 + digit, with a valid/ready handshake on both sides.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int OUT_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       bcd_2,
    input  logic [3:0]       bcd_1,
    input  logic [3:0]       bcd_0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] bin_out,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            state;
    stateT            nextState;

    logic [3:0]       digitIn  [4];
    logic [3:0]       digitReg [4];
    logic [1:0]       idx;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] accNext;
    logic             errInt;
    logic             errNext;
    logic [3:0]       curDigit;
    logic [OUT_W-1:0] binReg;
    logic             errReg;

    // Shift-and-add form of acc*10 + d; wraps modulo 2^OUT_W on invalid digits.
    function automatic logic [OUT_W-1:0] mulAdd10(input logic [OUT_W-1:0] a,
                                                  input logic [3:0]       d);
        return (a << 3) + (a << 1) + OUT_W'(d);
    endfunction

    function automatic logic isBadDigit(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    // Ports only carry three digits; a fourth position is treated as zero.
    assign digitIn[0] = bcd_0;
    assign digitIn[1] = bcd_1;
    assign digitIn[2] = bcd_2;
    assign digitIn[3] = 4'd0;

    assign curDigit = digitReg[idx];
    assign accNext  = mulAdd10(acc, curDigit);
    assign errNext  = errInt | isBadDigit(curDigit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (in_valid)    nextState = CONV;
            CONV:    if (idx == 2'd0) nextState = DONE;
            DONE:    if (out_ready)   nextState = IDLE;
            default:                  nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Result registers load on the final CONV edge, so DONE outputs are
    // registered and simply hold until the next conversion finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) digitReg[i] <= 4'd0;
            acc    <= '0;
            idx    <= 2'd0;
            errInt <= 1'b0;
            binReg <= '0;
            errReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 4; i++)
                            digitReg[i] <= (i < DIGITS) ? digitIn[i] : 4'd0;
                        acc    <= '0;
                        idx    <= 2'(DIGITS - 1);
                        errInt <= 1'b0;
                    end
                end
                CONV: begin
                    acc    <= accNext;
                    errInt <= errNext;
                    idx    <= idx - 2'd1;
                    if (idx == 2'd0) begin
                        binReg <= errNext ? '0 : accNext;
                        errReg <= errNext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bin_out = binReg;
    assign err     = errReg;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: latency, extremes, invalid digits,
// backpressure, input isolation after capture and asynchronous reset.
module tb_bcd_to_bin_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] bcd_2, bcd_1, bcd_0;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] bin_out;
    logic       err;

    int total = 0;
    int bad   = 0;

    bcd_to_bin_seq #(.DIGITS(3), .OUT_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .bcd_2(bcd_2), .bcd_1(bcd_1), .bcd_0(bcd_0),
        .out_valid(out_valid), .out_ready(out_ready),
        .bin_out(bin_out), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents digits for one accept edge, then counts edges until out_valid.
    task automatic doConv(input logic [3:0] d2, input logic [3:0] d1,
                          input logic [3:0] d0, output int edges);
        bcd_2 = d2; bcd_1 = d1; bcd_0 = d0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 12) begin
            tick();
            edges++;
        end
    endtask

    task automatic release1();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 10'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b bin_out=%0d err=%b, need 1 0 0 0",
                     in_ready, out_valid, bin_out, err);
        end
    endtask

    task automatic test_basic();
        int e;
        doConv(4'd1, 4'd9, 4'd8, e);
        total++;
        if (e !== 3) begin bad++; $display("FAIL basic_latency: got %0d edges, need 3", e); end
        total++;
        if (bin_out !== 10'd198 || err !== 1'b0) begin
            bad++; $display("FAIL basic_value: bin_out=%0d err=%b, need 198 0", bin_out, err);
        end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy: in_ready=%b, need 0", in_ready); end
        release1();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || bin_out !== 10'd198) begin
            bad++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b bin_out=%0d, need 0 1 198",
                     out_valid, in_ready, bin_out);
        end
    endtask

    task automatic test_extremes();
        logic [3:0] d2 [3] = '{4'd0, 4'd9, 4'd0};
        logic [3:0] d1 [3] = '{4'd0, 4'd9, 4'd2};
        logic [3:0] d0 [3] = '{4'd0, 4'd9, 4'd2};
        int         exp [3] = '{0, 999, 22};
        int e;
        for (int i = 0; i < 3; i++) begin
            doConv(d2[i], d1[i], d0[i], e);
            total++;
            if (e !== 3 || bin_out !== 10'(exp[i]) || err !== 1'b0) begin
                bad++;
                $display("FAIL extreme_%0d: edges=%0d bin_out=%0d err=%b, need 3 %0d 0",
                         i, e, bin_out, err, exp[i]);
            end
            release1();
        end
    endtask

    task automatic test_invalid();
        int e;
        doConv(4'd1, 4'hA, 4'd1, e);
        total++;
        if (e !== 3 || bin_out !== 10'd0 || err !== 1'b1) begin
            bad++;
            $display("FAIL invalid_digit: edges=%0d bin_out=%0d err=%b, need 3 0 1", e, bin_out, err);
        end
        release1();
        total++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL invalid_hold: err=%b out_valid=%b, need 1 0", err, out_valid);
        end
        doConv(4'd0, 4'd4, 4'd4, e);
        total++;
        if (bin_out !== 10'd44 || err !== 1'b0) begin
            bad++; $display("FAIL err_clears: bin_out=%0d err=%b, need 44 0", bin_out, err);
        end
        release1();
    endtask

    task automatic test_backpressure();
        int e;
        int badHold = 0;
        doConv(4'd3, 4'd2, 4'd1, e);
        bcd_2 = 4'd7; bcd_1 = 4'd7; bcd_0 = 4'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || bin_out !== 10'd321 || err !== 1'b0 || in_ready !== 1'b0)
                badHold++;
        end
        total++;
        if (badHold != 0) begin
            bad++;
            $display("FAIL bp_hold: %0d bad cycles, last out_valid=%b bin_out=%0d in_ready=%b, need 1 321 0",
                     badHold, out_valid, bin_out, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 10'd321) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b bin_out=%0d, need 1 0 321",
                     in_ready, out_valid, bin_out);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_reaccept: in_ready=%b, need 0", in_ready); end
        e = 0;
        while (!out_valid && e < 12) begin tick(); e++; end
        total++;
        if (e !== 3 || bin_out !== 10'd777) begin
            bad++; $display("FAIL bp_second: edges=%0d bin_out=%0d, need 3 777", e, bin_out);
        end
        release1();
    endtask

    task automatic test_input_change();
        int e;
        bcd_2 = 4'd0; bcd_1 = 4'd1; bcd_0 = 4'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bcd_2 = 4'd9; bcd_1 = 4'd9; bcd_0 = 4'd9;
        e = 0;
        while (!out_valid && e < 12) begin tick(); e++; end
        total++;
        if (e !== 3 || bin_out !== 10'd11 || err !== 1'b0) begin
            bad++; $display("FAIL input_change: edges=%0d bin_out=%0d err=%b, need 3 11 0", e, bin_out, err);
        end
        release1();
    endtask

    task automatic test_reset_mid();
        int e;
        bcd_2 = 4'd1; bcd_1 = 4'd2; bcd_0 = 4'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || bin_out !== 10'd0 || err !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_async: out_valid=%b bin_out=%0d err=%b in_ready=%b, need 0 0 0 1",
                     out_valid, bin_out, err, in_ready);
        end
        tick();
        #2 rst_n = 1'b1;
        tick();
        doConv(4'd1, 4'd0, 4'd0, e);
        total++;
        if (e !== 3 || bin_out !== 10'd100 || err !== 1'b0) begin
            bad++; $display("FAIL reset_recover: edges=%0d bin_out=%0d err=%b, need 3 100 0", e, bin_out, err);
        end
        release1();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        bcd_2 = 4'd0; bcd_1 = 4'd0; bcd_0 = 4'd0;
        #23;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_extremes();
        test_invalid();
        test_backpressure();
        test_input_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
